// File: rtl/atuador_irrigacao.sv
// Valve/pump sequencer for the irrigation actuators: valve settles before the pump
// starts and after it stops, with min/max pump time and cooldown. Dry-run guard: IRRIG_DRYRUN_EN.
module atuador_irrigacao #(
    parameter int CNT_W        = 16,
    parameter int VALVE_SETTLE = 4,
    parameter int MIN_ON       = 16,
    parameter int MAX_ON       = 256,
    parameter int COOLDOWN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Vs,
    input  logic       Bs,
    input  logic       L,
    input  logic       CLR,
    output logic       VALV_ASP,
    output logic       VALV_GOT,
    output logic       BOMBA,
    output logic       TMO,
    output logic       ALARM,
    output logic [2:0] ESTADO
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABRE   = 3'd1,
        RUN    = 3'd2,
        FECHA  = 3'd3,
        ESPERA = 3'd4
    } estado_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(VALVE_SETTLE - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN - 1);

    estado_t          state_q, state_d;
    logic             mode_q, mode_d;     // 1 = sprinkler, 0 = drip
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             alarm_q, alarm_d;
    logic             alarm_set;
    logic             dry_w;
    logic             clr_w;
    logic             req_w;

`ifdef IRRIG_DRYRUN_EN
    assign dry_w = ~L;
    assign clr_w = CLR;
`else
    logic unused_dryrun;
    assign dry_w        = 1'b0;
    assign clr_w        = 1'b0;
    assign unused_dryrun = L ^ CLR;
`endif

    assign req_w = mode_q ? Vs : Bs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q + CNT_W'(1);
        tmo_d     = 1'b0;
        alarm_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Vs | Bs) begin
                    if (dry_w) begin
                        alarm_set = 1'b1;
                    end else if (!alarm_q) begin
                        state_d = ABRE;
                        mode_d  = Vs;
                    end
                end
            end
            ABRE: begin
                if (dry_w) begin
                    state_d   = FECHA;
                    alarm_set = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Dry-run abort takes precedence over the MAX_ON timeout.
                if (dry_w) begin
                    state_d   = FECHA;
                    alarm_set = 1'b1;
                end else if (cnt_q == MAX_LAST) begin
                    state_d = FECHA;
                    tmo_d   = 1'b1;
                end else if (!req_w && (cnt_q >= MIN_LAST)) begin
                    state_d = FECHA;
                end
            end
            FECHA: begin
                if (cnt_q == SETTLE_LAST) state_d = ESPERA;
            end
            ESPERA: begin
                if (cnt_q == COOL_LAST) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        alarm_d = alarm_set | (alarm_q & ~clr_w);
    end

    always_comb begin
        VALV_ASP = 1'b0;
        VALV_GOT = 1'b0;
        BOMBA    = 1'b0;
        if (state_q == ABRE || state_q == RUN || state_q == FECHA) begin
            VALV_ASP = mode_q;
            VALV_GOT = ~mode_q;
        end
        if (state_q == RUN) BOMBA = 1'b1;
    end

    assign TMO    = tmo_q;
    assign ALARM  = alarm_q;
    assign ESTADO = state_q;

endmodule

// File: tb/tb_atuador_irrigacao.sv
// Directed scoreboard bench for atuador_irrigacao: per-cycle expected output vectors
// are queued ahead of the stimulus and popped one per clock edge.
module tb_atuador_irrigacao;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Vs  = 1'b0;
    logic       Bs  = 1'b0;
    logic       L   = 1'b1;
    logic       CLR = 1'b0;
    logic       VALV_ASP, VALV_GOT, BOMBA, TMO, ALARM;
    logic [2:0] ESTADO;

    logic [7:0] exp_q[$];
    int         ncmp  = 0;
    int         nfail = 0;
    string      phase = "reset";

    atuador_irrigacao dut (
        .clk      (clk),
        .rst      (rst),
        .Vs       (Vs),
        .Bs       (Bs),
        .L        (L),
        .CLR      (CLR),
        .VALV_ASP (VALV_ASP),
        .VALV_GOT (VALV_GOT),
        .BOMBA    (BOMBA),
        .TMO      (TMO),
        .ALARM    (ALARM),
        .ESTADO   (ESTADO)
    );

    always #5 clk = ~clk;

    // Vector layout: {VALV_ASP, VALV_GOT, BOMBA, TMO, ALARM, ESTADO[2:0]}
    function automatic logic [7:0] ev(input logic asp, input logic got, input logic bomba,
                                      input logic tmo, input logic alarm, input logic [2:0] est);
        return {asp, got, bomba, tmo, alarm, est};
    endfunction

    task automatic push(input int n, input logic [7:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    // One full activation as seen from the first ABRE cycle to the last ESPERA cycle.
    task automatic push_act(input logic asp, input int run_len, input logic tmo, input logic alarm);
        push(4,       ev(asp, !asp, 1'b0, 1'b0, alarm, 3'd1));
        push(run_len, ev(asp, !asp, 1'b1, 1'b0, alarm, 3'd2));
        push(1,       ev(asp, !asp, 1'b0, tmo,  alarm, 3'd3));
        push(3,       ev(asp, !asp, 1'b0, 1'b0, alarm, 3'd3));
        push(8,       ev(1'b0, 1'b0, 1'b0, 1'b0, alarm, 3'd4));
    endtask

    task automatic drain(input int n);
        logic [7:0] obs;
        logic [7:0] expv;
        repeat (n) begin
            @(posedge clk);
            #1;
            obs = {VALV_ASP, VALV_GOT, BOMBA, TMO, ALARM, ESTADO};
            ncmp++;
            if (exp_q.size() == 0) begin
                nfail++;
                $error("FAIL %s: scoreboard empty, observed=%b", phase, obs);
            end else begin
                expv = exp_q.pop_front();
                assert (obs === expv) else begin
                    nfail++;
                    $error("FAIL %s: observed=%b expected=%b (asp,got,bomba,tmo,alarm,estado)",
                           phase, obs, expv);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        phase = "reset";
        push(2, 8'h00);
        drain(2);
        rst = 1'b0;

        // Single-cycle Vs pulse: minimum run
        phase = "vs_pulse";
        Vs = 1'b1;
        push_act(1'b1, 16, 1'b0, 1'b0);
        push(2, 8'h00);
        drain(1);
        Vs = 1'b0;
        drain(exp_q.size());

        // Bs held 600 cycles: two MAX_ON timeouts, then a third run ends on release
        phase = "bs_long";
        Bs = 1'b1;
        push_act(1'b0, 256, 1'b1, 1'b0);
        push(1, 8'h00);
        push_act(1'b0, 256, 1'b1, 1'b0);
        push(1, 8'h00);
        push_act(1'b0, 50, 1'b0, 1'b0);
        push(2, 8'h00);
        drain(600);
        Bs = 1'b0;
        drain(exp_q.size());

        // Both requests together: sprinkler first, drip served after cooldown
        phase = "both_req";
        Vs = 1'b1;
        Bs = 1'b1;
        push_act(1'b1, 16, 1'b0, 1'b0);
        push(1, 8'h00);
        push_act(1'b0, 16, 1'b0, 1'b0);
        push(2, 8'h00);
        drain(1);
        Vs = 1'b0;
        drain(33);
        Bs = 1'b0;
        drain(exp_q.size());

        // Reset during RUN cycle 10
        phase = "rst_in_run";
        Vs = 1'b1;
        push(4,  ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        push(10, ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
        drain(14);
        rst = 1'b1;
        push(1, 8'h00);
        drain(1);
        rst = 1'b0;
        Vs  = 1'b0;
        push(2, 8'h00);
        drain(2);

        // Tank level drops at RUN cycle 3 with Vs held, later CLR
        phase = "dry_run";
`ifdef IRRIG_DRYRUN_EN
        push(4, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        push(3, ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
        push(4, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3));
        push(8, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
        push(3, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        push(1, 8'h00);
        push_act(1'b1, 16, 1'b0, 1'b0);
        push(2, 8'h00);
`else
        push_act(1'b1, 20, 1'b0, 1'b0);
        push(2, 8'h00);
`endif
        Vs = 1'b1;
        drain(7);
        L = 1'b0;
        drain(1);
        L = 1'b1;
        drain(14);
        CLR = 1'b1;
        drain(1);
        CLR = 1'b0;
        drain(1);
        Vs = 1'b0;
        drain(exp_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
